// File: rtl/funct_generator_cfg_ctrl_pkg.sv
// Shared types, register indices and reset values for the function generator
// configuration sequencer.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif
`ifndef RESET_AMP
`define RESET_AMP 16'h0100
`endif
`ifndef RESET_VALUE
`define RESET_VALUE 16'h0000
`endif

package funct_generator_cfg_ctrl_pkg;

    localparam int CFG_DATA_WIDTH = `DATA_WIDTH;
    localparam int CFG_NUM_REGS   = 3;

    localparam int REG_FREQ = 0;
    localparam int REG_AMP  = 1;
    localparam int REG_WAVE = 2;

    localparam logic [CFG_DATA_WIDTH-1:0] CFG_RESET_AMP   = CFG_DATA_WIDTH'(`RESET_AMP);
    localparam logic [CFG_DATA_WIDTH-1:0] CFG_RESET_VALUE = CFG_DATA_WIDTH'(`RESET_VALUE);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        WRITE = 2'd2,
        CLEAR = 2'd3
    } cfg_state_t;

    // Power-on / clear value of each shadow register
    function automatic logic [CFG_DATA_WIDTH-1:0] reg_reset_value(input int idx);
        logic [CFG_DATA_WIDTH-1:0] val;
        case (idx)
            REG_FREQ: val = CFG_RESET_VALUE;
            REG_AMP:  val = CFG_RESET_AMP;
            REG_WAVE: val = CFG_RESET_VALUE;
            default:  val = CFG_RESET_VALUE;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/funct_generator_cfg_ctrl_if.sv
// Host write channel into the configuration sequencer (valid/ready handshake).
interface funct_generator_cfg_ctrl_if
    import funct_generator_cfg_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = CFG_DATA_WIDTH
);
    logic                  wr_valid;
    logic                  wr_ready;
    logic [1:0]            wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;

    modport master (
        output wr_valid,
        output wr_addr,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_addr,
        input  wr_data,
        output wr_ready
    );
endinterface

// File: rtl/funct_generator_cfg_picker.sv
// Lowest-set-bit priority encoder over the dirty mask: one-hot, index, any.
module funct_generator_cfg_picker #(
    parameter int NUM_REGS = 3,
    parameter int IDX_W    = 2
) (
    input  logic [NUM_REGS-1:0] dirty,
    output logic [NUM_REGS-1:0] onehot,
    output logic [IDX_W-1:0]    index,
    output logic                any
);

    // Two's-complement trick isolates the lowest set bit; then encode it
    always_comb begin
        onehot = dirty & (~dirty + NUM_REGS'(1));
        any    = |dirty;
        index  = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            index = index | (onehot[i] ? IDX_W'(i) : IDX_W'(0));
        end
    end

endmodule

// File: rtl/funct_generator_cfg_ctrl.sv
// Configuration sequencer: buffers host writes in shadows and pushes dirty
// registers to the live generator registers only at a phase-wrap sync.
module funct_generator_cfg_ctrl
    import funct_generator_cfg_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH   = CFG_DATA_WIDTH,
    parameter int NUM_REGS     = CFG_NUM_REGS,
    parameter int SYNC_TIMEOUT = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    funct_generator_cfg_ctrl_if.slave bus,
    input  logic                      commit_req,
    input  logic                      clear_req,
    input  logic                      sync,
    output logic [DATA_WIDTH-1:0]     reg_d,
    output logic [NUM_REGS-1:0]       reg_enh,
    output logic [NUM_REGS-1:0]       reg_clrh,
    output logic                      busy,
    output logic                      commit_done,
    output logic                      timeout_flag,
    output logic                      err_addr
);

    localparam int TIMER_W = $clog2(SYNC_TIMEOUT + 1);
    localparam int IDX_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    cfg_state_t            state_r;
    logic [NUM_REGS-1:0]   dirty_r;
    logic [DATA_WIDTH-1:0] shadow_r [NUM_REGS];
    logic [TIMER_W-1:0]    timer_r;
    logic                  clear_pend_r;
    logic                  ready_r;
    logic [DATA_WIDTH-1:0] reg_d_r;
    logic [NUM_REGS-1:0]   reg_enh_r;
    logic [NUM_REGS-1:0]   reg_clrh_r;
    logic                  commit_done_r;
    logic                  timeout_flag_r;
    logic                  err_addr_r;

    logic                  wr_ready_s;
    logic                  wr_fire_s;
    logic                  addr_ok_s;
    logic [NUM_REGS-1:0]   wr_sel_s;
    logic [NUM_REGS-1:0]   dirty_next_s;
    logic [NUM_REGS-1:0]   pick_onehot_s;
    logic [IDX_W-1:0]      pick_idx_s;
    logic                  pick_any_s;

    funct_generator_cfg_picker #(
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W)
    ) u_picker (
        .dirty  (dirty_r),
        .onehot (pick_onehot_s),
        .index  (pick_idx_s),
        .any    (pick_any_s)
    );

    // Host handshake: a coincident clear_req steals the cycle from a write
    always_comb begin
        wr_ready_s   = ready_r && (state_r == IDLE) && !clear_req;
        wr_fire_s    = bus.wr_valid && wr_ready_s;
        addr_ok_s    = ({30'd0, bus.wr_addr} < 32'(NUM_REGS));
        wr_sel_s     = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            wr_sel_s[i] = wr_fire_s && addr_ok_s && ({30'd0, bus.wr_addr} == 32'(i));
        end
        dirty_next_s = dirty_r | wr_sel_s;
    end

    assign bus.wr_ready  = wr_ready_s;
    assign busy          = (state_r != IDLE) || clear_pend_r;
    assign reg_d         = reg_d_r;
    assign reg_enh       = reg_enh_r;
    assign reg_clrh      = reg_clrh_r;
    assign commit_done   = commit_done_r;
    assign timeout_flag  = timeout_flag_r;
    assign err_addr      = err_addr_r;

    // Sequencer FSM; enh/clrh are staged one edge ahead so they line up with WRITE/CLEAR
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= IDLE;
            dirty_r        <= '0;
            timer_r        <= '0;
            clear_pend_r   <= 1'b0;
            ready_r        <= 1'b0;
            reg_d_r        <= '0;
            reg_enh_r      <= '0;
            reg_clrh_r     <= '0;
            commit_done_r  <= 1'b0;
            timeout_flag_r <= 1'b0;
            err_addr_r     <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                shadow_r[i] <= DATA_WIDTH'(reg_reset_value(i));
            end
        end else begin
            ready_r       <= 1'b1;
            reg_d_r       <= '0;
            reg_enh_r     <= '0;
            reg_clrh_r    <= '0;
            commit_done_r <= 1'b0;
            err_addr_r    <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (clear_req) begin
                        state_r    <= CLEAR;
                        reg_clrh_r <= {NUM_REGS{1'b1}};
                    end else begin
                        for (int i = 0; i < NUM_REGS; i++) begin
                            if (wr_sel_s[i]) begin
                                shadow_r[i] <= bus.wr_data;
                            end
                        end
                        dirty_r    <= dirty_next_s;
                        err_addr_r <= wr_fire_s && !addr_ok_s;
                        if (commit_req) begin
                            if (dirty_next_s == '0) begin
                                commit_done_r <= 1'b1;
                            end else begin
                                state_r        <= ARMED;
                                timer_r        <= TIMER_W'(SYNC_TIMEOUT);
                                timeout_flag_r <= 1'b0;
                            end
                        end
                    end
                end
                ARMED: begin
                    if (clear_req) begin
                        state_r    <= CLEAR;
                        reg_clrh_r <= {NUM_REGS{1'b1}};
                    end else if (sync || (timer_r == TIMER_W'(1))) begin
                        state_r   <= WRITE;
                        reg_enh_r <= pick_onehot_s;
                        reg_d_r   <= shadow_r[pick_idx_s];
                        dirty_r   <= dirty_r & ~pick_onehot_s;
                        if (!sync) begin
                            timeout_flag_r <= 1'b1;
                        end
                    end else begin
                        timer_r <= timer_r - TIMER_W'(1);
                    end
                end
                WRITE: begin
                    if (clear_req) begin
                        clear_pend_r <= 1'b1;
                    end
                    if (pick_any_s) begin
                        reg_enh_r <= pick_onehot_s;
                        reg_d_r   <= shadow_r[pick_idx_s];
                        dirty_r   <= dirty_r & ~pick_onehot_s;
                    end else begin
                        commit_done_r <= 1'b1;
                        if (clear_pend_r || clear_req) begin
                            state_r    <= CLEAR;
                            reg_clrh_r <= {NUM_REGS{1'b1}};
                        end else begin
                            state_r <= IDLE;
                        end
                    end
                end
                CLEAR: begin
                    // A clear_req arriving here is redundant with the clear in progress
                    dirty_r      <= '0;
                    clear_pend_r <= 1'b0;
                    state_r      <= IDLE;
                    for (int i = 0; i < NUM_REGS; i++) begin
                        shadow_r[i] <= DATA_WIDTH'(reg_reset_value(i));
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_funct_generator_cfg_ctrl.sv
// Self-checking bench: directed scenarios plus randomized write/commit rounds
// against an array-based model of shadows, dirty flags and live registers.
module tb_funct_generator_cfg_ctrl;
    import funct_generator_cfg_ctrl_pkg::*;

    localparam int DW = CFG_DATA_WIDTH;
    localparam int NR = 3;

    logic          clk;
    logic          rst;
    logic          commit_req;
    logic          clear_req;
    logic          sync;
    logic [DW-1:0] reg_d;
    logic [NR-1:0] reg_enh;
    logic [NR-1:0] reg_clrh;
    logic          busy;
    logic          commit_done;
    logic          timeout_flag;
    logic          err_addr;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] shadow_m [NR];
    logic          dirty_m  [NR];
    logic [DW-1:0] live_m   [NR];
    logic          tm_m;
    logic [DW-1:0] live_q   [NR];

    funct_generator_cfg_ctrl_if #(.DATA_WIDTH(DW)) bus ();

    funct_generator_cfg_ctrl #(
        .DATA_WIDTH   (DW),
        .NUM_REGS     (NR),
        .SYNC_TIMEOUT (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .commit_req   (commit_req),
        .clear_req    (clear_req),
        .sync         (sync),
        .reg_d        (reg_d),
        .reg_enh      (reg_enh),
        .reg_clrh     (reg_clrh),
        .busy         (busy),
        .commit_done  (commit_done),
        .timeout_flag (timeout_flag),
        .err_addr     (err_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural funct_generator_register instances driven by the DUT outputs
    always @(posedge clk) begin
        for (int i = 0; i < NR; i++) begin
            if (rst || reg_clrh[i]) live_q[i] <= '0;
            else if (reg_enh[i])    live_q[i] <= reg_d;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_live();
        for (int i = 0; i < NR; i++) chk($sformatf("live_q%0d", i), 32'(live_q[i]), 32'(live_m[i]));
    endtask

    task automatic model_clear();
        shadow_m[0] = CFG_RESET_VALUE;
        shadow_m[1] = CFG_RESET_AMP;
        shadow_m[2] = CFG_RESET_VALUE;
        for (int i = 0; i < NR; i++) begin
            dirty_m[i] = 1'b0;
            live_m[i]  = '0;
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [DW-1:0] dv);
        bus.wr_valid = 1'b1;
        bus.wr_addr  = a;
        bus.wr_data  = dv;
        #1;
        chk("wr_ready", 32'(bus.wr_ready), 32'd1);
        cyc();
        bus.wr_valid = 1'b0;
        if (a < 2'd3) begin
            shadow_m[a] = dv;
            dirty_m[a]  = 1'b1;
        end
        chk("err_addr", 32'(err_addr), 32'(a == 2'd3));
    endtask

    // Commit with sync raised dly ARMED cycles after entry; sync is also high
    // in the accept cycle, which must not count
    task automatic do_commit(input int dly, input bit with_wr, input logic [1:0] a, input logic [DW-1:0] dv);
        int exp_q[$];
        commit_req = 1'b1;
        sync       = 1'b1;
        if (with_wr) begin
            bus.wr_valid = 1'b1;
            bus.wr_addr  = a;
            bus.wr_data  = dv;
            if (a < 2'd3) begin
                shadow_m[a] = dv;
                dirty_m[a]  = 1'b1;
            end
        end
        for (int i = 0; i < NR; i++) if (dirty_m[i]) exp_q.push_back(i);
        if (exp_q.size() != 0) tm_m = 1'b0;
        #1;
        chk("commit_wr_ready", 32'(bus.wr_ready), 32'd1);
        cyc();
        commit_req   = 1'b0;
        sync         = 1'b0;
        bus.wr_valid = 1'b0;
        chk("commit_err", 32'(err_addr), 32'(with_wr && (a == 2'd3)));
        chk("commit_tflag", 32'(timeout_flag), 32'(tm_m));
        if (exp_q.size() == 0) begin
            chk("empty_done", 32'(commit_done), 32'd1);
            chk("empty_busy", 32'(busy), 32'd0);
        end else begin
            chk("armed_busy", 32'(busy), 32'd1);
            chk("armed_done", 32'(commit_done), 32'd0);
            chk("armed_ready", 32'(bus.wr_ready), 32'd0);
            repeat (dly) begin
                cyc();
                chk("armed_enh", 32'(reg_enh), 32'd0);
            end
            sync = 1'b1;
            cyc();
            sync = 1'b0;
            foreach (exp_q[k]) begin
                if (k > 0) cyc();
                chk("write_enh", 32'(reg_enh), 32'd1 << exp_q[k]);
                chk("write_d", 32'(reg_d), 32'(shadow_m[exp_q[k]]));
                chk("write_done", 32'(commit_done), 32'd0);
            end
            cyc();
            chk("done_pulse", 32'(commit_done), 32'd1);
            chk("done_enh", 32'(reg_enh), 32'd0);
            chk("done_d", 32'(reg_d), 32'd0);
            chk("done_busy", 32'(busy), 32'd0);
            foreach (exp_q[k]) begin
                live_m[exp_q[k]]  = shadow_m[exp_q[k]];
                dirty_m[exp_q[k]] = 1'b0;
            end
            chk_live();
        end
    endtask

    initial begin
        rst          = 1'b1;
        commit_req   = 1'b0;
        clear_req    = 1'b0;
        sync         = 1'b0;
        bus.wr_valid = 1'b0;
        bus.wr_addr  = 2'd0;
        bus.wr_data  = '0;
        model_clear();
        tm_m = 1'b0;

        // Reset: all outputs low, ready one cycle after release, empty commit
        repeat (3) cyc();
        chk("rst_d", 32'(reg_d), 32'd0);
        chk("rst_enh", 32'(reg_enh), 32'd0);
        chk("rst_clrh", 32'(reg_clrh), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(commit_done), 32'd0);
        chk("rst_tflag", 32'(timeout_flag), 32'd0);
        chk("rst_err", 32'(err_addr), 32'd0);
        chk("rst_ready", 32'(bus.wr_ready), 32'd0);
        rst = 1'b0;
        cyc();
        chk("post_rst_ready", 32'(bus.wr_ready), 32'd1);
        do_commit(0, 1'b0, 2'd0, '0);

        // freq/amp commit with sync 5 cycles into ARMED
        wr(2'd0, DW'(16'h0010));
        wr(2'd1, DW'(16'h0200));
        do_commit(5, 1'b0, 2'd0, '0);

        // No sync: forced write after exactly 8 ARMED cycles
        wr(2'd2, DW'(16'h0003));
        commit_req = 1'b1;
        cyc();
        commit_req = 1'b0;
        chk("to_busy", 32'(busy), 32'd1);
        for (int k = 1; k < 8; k++) begin
            cyc();
            chk("to_wait_enh", 32'(reg_enh), 32'd0);
        end
        cyc();
        chk("to_enh", 32'(reg_enh), 32'b100);
        chk("to_d", 32'(reg_d), 32'h0003);
        chk("to_tflag", 32'(timeout_flag), 32'd1);
        cyc();
        chk("to_done", 32'(commit_done), 32'd1);
        live_m[2]  = shadow_m[2];
        dirty_m[2] = 1'b0;
        tm_m       = 1'b1;
        chk_live();
        do_commit(0, 1'b0, 2'd0, '0);
        wr(2'd0, DW'(16'h0777));
        do_commit(2, 1'b0, 2'd0, '0);

        // clear_req while ARMED aborts the commit
        wr(2'd1, DW'(16'h1234));
        commit_req = 1'b1;
        cyc();
        commit_req = 1'b0;
        cyc();
        clear_req = 1'b1;
        cyc();
        clear_req = 1'b0;
        chk("ca_clrh", 32'(reg_clrh), 32'b111);
        chk("ca_enh", 32'(reg_enh), 32'd0);
        chk("ca_done", 32'(commit_done), 32'd0);
        model_clear();
        cyc();
        chk("ca_clrh_end", 32'(reg_clrh), 32'd0);
        chk("ca_done_end", 32'(commit_done), 32'd0);
        chk("ca_busy_end", 32'(busy), 32'd0);
        chk_live();
        do_commit(0, 1'b0, 2'd0, '0);

        // clear_req during a 3-register WRITE runs after it completes
        wr(2'd0, DW'(16'h0aa1));
        wr(2'd1, DW'(16'h0bb2));
        wr(2'd2, DW'(16'h0cc3));
        commit_req = 1'b1;
        cyc();
        commit_req = 1'b0;
        cyc();
        sync = 1'b1;
        cyc();
        sync = 1'b0;
        chk("cw_enh0", 32'(reg_enh), 32'b001);
        clear_req = 1'b1;
        cyc();
        clear_req = 1'b0;
        chk("cw_enh1", 32'(reg_enh), 32'b010);
        chk("cw_clrh1", 32'(reg_clrh), 32'd0);
        cyc();
        chk("cw_enh2", 32'(reg_enh), 32'b100);
        chk("cw_d2", 32'(reg_d), 32'h0cc3);
        cyc();
        chk("cw_done", 32'(commit_done), 32'd1);
        chk("cw_clrh", 32'(reg_clrh), 32'b111);
        chk("cw_enh_off", 32'(reg_enh), 32'd0);
        for (int i = 0; i < NR; i++) live_m[i] = shadow_m[i];
        chk_live();
        model_clear();
        cyc();
        chk("cw_clrh_end", 32'(reg_clrh), 32'd0);
        chk("cw_busy_end", 32'(busy), 32'd0);
        chk_live();

        // Out-of-range address: error pulse, nothing marked dirty
        wr(2'd3, DW'(16'hdead));
        cyc();
        chk("err_clears", 32'(err_addr), 32'd0);
        do_commit(0, 1'b0, 2'd0, '0);

        // Same-cycle clear/commit/write in IDLE: clear wins, the others drop
        clear_req    = 1'b1;
        commit_req   = 1'b1;
        bus.wr_valid = 1'b1;
        bus.wr_addr  = 2'd0;
        bus.wr_data  = DW'(16'h5555);
        #1;
        chk("prio_ready", 32'(bus.wr_ready), 32'd0);
        cyc();
        clear_req    = 1'b0;
        commit_req   = 1'b0;
        bus.wr_valid = 1'b0;
        chk("prio_clrh", 32'(reg_clrh), 32'b111);
        chk("prio_done", 32'(commit_done), 32'd0);
        model_clear();
        cyc();
        do_commit(0, 1'b0, 2'd0, '0);

        // Randomized write/commit rounds
        for (int it = 0; it < 15; it++) begin
            int nw;
            nw = int'($urandom_range(0, 3));
            for (int w = 0; w < nw; w++) begin
                wr(2'($urandom_range(0, 3)), DW'($urandom));
            end
            do_commit(int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)),
                      2'($urandom_range(0, 3)), DW'($urandom));
        end

        // Reset in the middle of WRITE abandons the remaining writes
        wr(2'd0, DW'(16'h0101));
        wr(2'd2, DW'(16'h0202));
        commit_req = 1'b1;
        cyc();
        commit_req = 1'b0;
        sync = 1'b1;
        cyc();
        sync = 1'b0;
        chk("mr_enh", 32'(reg_enh), 32'b001);
        rst = 1'b1;
        cyc();
        chk("mr_enh_off", 32'(reg_enh), 32'd0);
        chk("mr_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        model_clear();
        tm_m = 1'b0;
        cyc();
        chk("mr_ready", 32'(bus.wr_ready), 32'd1);
        chk_live();
        do_commit(0, 1'b0, 2'd0, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
